// File: rtl/sobel_window_filter.sv
// 3x3 Sobel |Gx|+|Gy| over the line-buffer row taps, two-stage pipeline, saturated output.
// Build option SOBEL_THRESHOLD_EN adds a threshold port and binarises the output.
module sobel_window_filter #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] row0_pixel,
  input  logic [DATA_WIDTH-1:0] row1_pixel,
  input  logic [DATA_WIDTH-1:0] row2_pixel,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [DATA_WIDTH-1:0] threshold,
`endif
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_valid,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int GW = DATA_WIDTH + 3;
  localparam int MW = DATA_WIDTH + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [MW-1:0] SAT_MAX  = {{(MW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] tap [3];
  logic [DATA_WIDTH-1:0] w [3][3];
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  win_ok;
  logic                  win_valid, win_eol, win_eof;

  assign tap[0] = row0_pixel;
  assign tap[1] = row1_pixel;
  assign tap[2] = row2_pixel;
  assign win_ok = (col >= CW'(2)) && (row >= RW'(2));

  // Window shift and pixel position; win_* is a one-cycle tag for the pixel just accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
      if (frame_start) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[r][c] <= '0;
        col <= '0;
        row <= '0;
        if (en) begin
          for (int r = 0; r < 3; r++)
            w[r][0] <= tap[r];
          col <= CW'(1);
        end
      end else if (en) begin
        for (int r = 0; r < 3; r++) begin
          w[r][2] <= w[r][1];
          w[r][1] <= w[r][0];
          w[r][0] <= tap[r];
        end
        win_valid <= win_ok;
        win_eol   <= win_ok && (col == COL_LAST);
        win_eof   <= win_ok && (col == COL_LAST) && (row == ROW_LAST);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Each weighted sum is at most 4*(2^DATA_WIDTH-1), so the difference fits GW bits signed.
  logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  always_comb begin
    gx_pos = GW'(w[0][0]) + (GW'(w[1][0]) << 1) + GW'(w[2][0]);
    gx_neg = GW'(w[0][2]) + (GW'(w[1][2]) << 1) + GW'(w[2][2]);
    gy_pos = GW'(w[2][0]) + (GW'(w[2][1]) << 1) + GW'(w[2][2]);
    gy_neg = GW'(w[0][0]) + (GW'(w[0][1]) << 1) + GW'(w[0][2]);
  end

  logic signed [GW-1:0] gx_q, gy_q;
  logic                 s1_valid, s1_eol, s1_eof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_q     <= '0;
      gy_q     <= '0;
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      gx_q     <= $signed(gx_pos - gx_neg);
      gy_q     <= $signed(gy_pos - gy_neg);
      s1_valid <= win_valid;
      s1_eol   <= win_eol;
      s1_eof   <= win_eof;
    end
  end

  logic [GW-1:0]         ax, ay;
  logic [MW-1:0]         mag;
  logic [DATA_WIDTH-1:0] sat, pix_d;
  always_comb begin
    ax    = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay    = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag   = MW'(ax) + MW'(ay);
    sat   = (mag > SAT_MAX) ? {DATA_WIDTH{1'b1}} : mag[DATA_WIDTH-1:0];
`ifdef SOBEL_THRESHOLD_EN
    pix_d = (sat >= threshold) ? {DATA_WIDTH{1'b1}} : '0;
`else
    pix_d = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pixel <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_pixel <= pix_d;
      out_valid <= s1_valid;
      out_eol   <= s1_eol;
      out_eof   <= s1_eof;
    end
  end

endmodule

// File: tb/tb_sobel_window_filter.sv
// Randomized bench for sobel_window_filter on a small image; expected pixels come from a
// direct 3x3 Sobel over a bench-held image array, with exact output-cycle tracking.
module tb_sobel_window_filter;
  localparam int DW = 12;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NV = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] row0_pixel = '0, row1_pixel = '0, row2_pixel = '0;
`ifdef SOBEL_THRESHOLD_EN
  logic [DW-1:0] threshold = 12'd300;
`endif
  logic [DW-1:0] out_pixel;
  logic          out_valid, out_eol, out_eof;

  sobel_window_filter #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .row0_pixel(row0_pixel), .row1_pixel(row1_pixel), .row2_pixel(row2_pixel),
`ifdef SOBEL_THRESHOLD_EN
    .threshold(threshold),
`endif
    .out_pixel(out_pixel), .out_valid(out_valid), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int pix; int eol; int eof; } exp_t;
  exp_t q[$];
  int   img [H][W];
  int   mcol = 0, mrow = 0, mode = 0;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   n_valid = 0, n_eol = 0, n_eof = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(int c);
    case (mode)
      1:       return 'h200;
      2:       return (c < W/2) ? 0 : 100;
      3:       return (c < W/2) ? 4095 : 0;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic int sobel_ref(int r, int c);
    int gx, gy, mag;
    gx = (img[r][c] + 2*img[r-1][c] + img[r-2][c])
       - (img[r][c-2] + 2*img[r-1][c-2] + img[r-2][c-2]);
    gy = (img[r-2][c] + 2*img[r-2][c-1] + img[r-2][c-2])
       - (img[r][c] + 2*img[r][c-1] + img[r][c-2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 4095) mag = 4095;
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= 300) ? 4095 : 0;
`else
    return mag;
`endif
  endfunction

  // One cycle of stimulus: drive at negedge, model the accept, return after the posedge.
  task automatic step(input bit do_en, input bit do_fs);
    @(negedge clk);
    en = do_en;
    frame_start = do_fs;
    if (do_fs) begin
      mcol = 0;
      mrow = 0;
    end
    if (do_en) begin
      if (mcol == 0 && mrow == 0)
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            img[r][c] = pick(c);
      row0_pixel = DW'(img[mrow][mcol]);
      row1_pixel = (mrow >= 1) ? DW'(img[mrow-1][mcol]) : '0;
      row2_pixel = (mrow >= 2) ? DW'(img[mrow-2][mcol]) : '0;
      if (mcol >= 2 && mrow >= 2)
        q.push_back('{due: cyc + 3, pix: sobel_ref(mrow, mcol),
                      eol: int'(mcol == W-1), eof: int'(mcol == W-1 && mrow == H-1)});
      if (mcol == W-1) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end else begin
      row0_pixel = DW'($urandom);
      row1_pixel = DW'($urandom);
      row2_pixel = DW'($urandom);
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("out_valid", int'(out_valid), 1);
      chk("out_pixel", int'(out_pixel), e.pix);
      chk("out_eol", int'(out_eol), e.eol);
      chk("out_eof", int'(out_eof), e.eof);
    end else begin
      chk("idle_valid", int'(out_valid), 0);
    end
    if (out_valid) begin
      n_valid++;
      if (out_eol) n_eol++;
      if (out_eof) n_eof++;
    end
  end

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    rst = 1'b1;

    mode = 1;
    n_valid = 0; n_eol = 0; n_eof = 0;
    repeat (W*H) step(1, 0);
    repeat (4) step(0, 0);
    chk("flat_valid_cnt", n_valid, NV);
    chk("flat_eol_cnt", n_eol, H - 2);
    chk("flat_eof_cnt", n_eof, 1);

    mode = 2;
    n_valid = 0;
    for (int k = 0; k < 3*W*H; k++) step(k % 3 == 0, 0);
    repeat (4) step(0, 0);
    chk("gap_valid_cnt", n_valid, NV);

    mode = 3;
    repeat (W*H) step(1, 0);
    repeat (4) step(0, 0);

    mode = 0;
    acc = 0;
    for (int k = 0; k < 8*W*H && acc < W*H; k++) begin
      bit b;
      b = ($urandom_range(0, 99) < 70);
      step(b, 0);
      if (b) acc++;
    end
    chk("rand_budget", acc, W*H);
    repeat (4) step(0, 0);

    for (int k = 0; k < W*H && !(mcol == 10 && mrow == 5); k++) step(1, 0);
    chk("fs_reach", mcol * 100 + mrow, 1005);
    step(1, 1);
    n_valid = 0;
    repeat (W*H - 1) step(1, 0);
    repeat (4) step(0, 0);
    chk("fs_valid_cnt", n_valid, NV + 2);

    for (int k = 0; k < W*H && !(mcol == 8 && mrow == 3); k++) step(1, 0);
    #2;
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b0;
    en = 1'b0;
    q.delete();
    mcol = 0;
    mrow = 0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_pixel", int'(out_pixel), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    n_valid = 0; n_eol = 0; n_eof = 0;
    repeat (W*H) step(1, 0);
    repeat (4) step(0, 0);
    chk("post_rst_valid_cnt", n_valid, NV);
    chk("post_rst_eol_cnt", n_eol, H - 2);
    chk("post_rst_eof_cnt", n_eof, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobel_window_filter.md
Name: sobel_window_filter

Overview:
- Consumes the three row taps of the line buffer, one column per pixel strobe.
- Assembles a 3x3 pixel window and computes the Sobel gradient magnitude |Gx|+|Gy|.
- Emits one filtered pixel per valid window. Windows that straddle the left border or the first two rows are suppressed.
- Sits between the line buffer and the output/VGA frame writer in the edge-detection datapath.

Parameters:
DATA_WIDTH, 12, pixel width (unsigned grayscale intensity)
IMG_WIDTH, 640, pixels per row; must match the line buffer row length
IMG_HEIGHT, 480, rows per frame

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
en  input  1  pixel strobe, same strobe that shifts the line buffer; one column accepted per cycle with en=1
frame_start  input  1  synchronous frame restart; clears counters and window
row0_pixel  input  DATA_WIDTH  newest-row tap (row y)
row1_pixel  input  DATA_WIDTH  middle-row tap (row y-1)
row2_pixel  input  DATA_WIDTH  oldest-row tap (row y-2)
out_pixel  output  DATA_WIDTH  gradient magnitude, saturated
out_valid  output  1  out_pixel valid this cycle
out_eol  output  1  with out_valid: last valid window of a row
out_eof  output  1  with out_valid: last valid window of the frame

Behaviour:
- Reset (rst=0, async): window registers, col/row counters, pipeline stages and all outputs = 0.
- Window: w[r][c], r = 0..2 (row0..row2), c = 0..2 (0 = newest column).
- On en=1: w[r][2]<=w[r][1], w[r][1]<=w[r][0], w[r][0]<=row r pixel. With en=0 the window holds.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) track the pixel being accepted.
- On en=1, col increments. At col=IMG_WIDTH-1 it wraps to 0 and row increments. At row=IMG_HEIGHT-1 with col wrap, row wraps to 0.
- Window valid flag: set when the accepted pixel has col>=2 and row>=2. Columns 0/1 of every row and rows 0/1 never produce output, so there is no wrap-around mixing.
- Stage 1, registered in the cycle after the accepting en:
  - Gx = (w00+2w10+w20) - (w02+2w12+w22)
  - Gy = (w20+2w21+w22) - (w00+2w01+w02)
  - Both are signed, width DATA_WIDTH+3.
- Stage 2, registered in the next cycle:
  - mag = |Gx|+|Gy| (unsigned, DATA_WIDTH+4).
  - out_pixel = min(mag, 2^DATA_WIDTH-1).
- Pipeline stages advance every clock, independent of en; a valid bit travels with the data.
- Latency: out_valid asserts exactly 2 cycles after the clk edge at which en accepted the completing pixel. out_valid is a 1-cycle pulse per window.
- Back-to-back en gives one output per cycle. Gaps in en give gaps in out_valid and nothing is lost.
- out_eol = out_valid and source col=IMG_WIDTH-1.
- out_eof = out_eol and source row=IMG_HEIGHT-1.
- frame_start=1: col, row and window cleared to 0. In-flight pipeline results still drain (outputs already in stages 1-2 are emitted).
  - frame_start with en in the same cycle: the pixel is accepted as col=0, row=0, and the counters become col=1, row=0 after that edge.
- Reset mid-frame: all state cleared immediately. In-flight outputs are discarded, and out_valid drops asynchronously.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- Defined: adds input port threshold (DATA_WIDTH). Stage 2 outputs out_pixel = all-ones if saturated mag >= threshold, else 0. Latency is unchanged.
- Undefined: no threshold port; out_pixel is the saturated magnitude.

Test Plan:
- Flat field (all rows = 0x200, 640x480, en continuous) -> out_pixel=0 on every valid output. Exactly 638*478 out_valid pulses, 478 out_eol pulses, 1 out_eof.
- Vertical step (pixels with col<320 = 0, others = 100) -> out_pixel=400 for source col 320 and 321, 0 elsewhere.
- Saturation (col<320 = 4095, others = 0) -> out_pixel=4095 at cols 320/321 (raw mag 16380). No wrap to small values.
- Latency/gaps:
  - en pulsed every 3rd cycle: first out_valid exactly 2 cycles after the en accepting col=2, row=2.
  - out_valid count equals the count of accepted valid windows.
  - No output for col 0/1 or row 0/1.
- frame_start mid-row (at col=100, row=50) with en same cycle -> next valid output only after col=2, row=2 of the new frame. The two pre-restart in-flight outputs still appear.
- Threshold build (SOBEL_THRESHOLD_EN, threshold=300), vertical step test -> out_pixel=0xFFF at cols 320/321, 0 elsewhere. Async rst mid-row -> out_valid=0 immediately and counters restart at 0.
